sort_engine_p: RTL and testbench



---
 rtl/sort_pkg.sv | 24 ++
 rtl/sort_ram.sv | 43 ++++
 rtl/sort_engine_p.sv | 175 +++++++++++++++++
 tb/tb_sort_engine_p.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and helpers for the in-place bubble-sort engine.
// Holds the FSM state encoding and the saturating counter step.
package sort_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_CMP,
        S_WR_LO,
        S_WR_HI,
        S_ADV,
        S_PASS_END,
        S_FINISH
    } state_t;

    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input logic [63:0] vmax
    );
        return (v >= vmax) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/sort_ram.sv
// Private sorter RAM: one muxed synchronous write port,
// a paired sort read port (mem[a], mem[a+1]) and a debug read port.
module sort_ram
    import sort_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          i_busy,
    input  logic          i_s_we,
    input  logic [AW-1:0] i_s_waddr,
    input  logic [DW-1:0] i_s_wdata,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    input  logic [AW-1:0] i_s_raddr,
    output logic [DW-1:0] o_s_lo,
    output logic [DW-1:0] o_s_hi,
    output logic [DW-1:0] o_d_dout
);

    logic [DW-1:0] r_mem [2**AW];
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    // The sorter owns the write port while busy; debug writes are dropped.
    assign w_we    = i_busy ? i_s_we    : i_d_we;
    assign w_waddr = i_busy ? i_s_waddr : i_d_addr;
    assign w_wdata = i_busy ? i_s_wdata : i_d_wdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign o_s_lo   = r_mem[i_s_raddr];
    assign o_s_hi   = r_mem[i_s_raddr + AW'(1)];
    assign o_d_dout = r_mem[i_d_addr];

endmodule

// File: rtl/sort_engine_p.sv
// Parametrised in-place bubble sorter over mem[1..n], n = mem[0].
// Shrinking pass bound, early exit, signed/desc modes, saturating counters.
module sort_engine_p
    import sort_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    input  logic          desc,
    input  logic          sgn,
    output logic          done,
    output logic [CW-1:0] cycles,
    output logic [CW-1:0] swaps,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_din,
    input  logic          dbg_we,
    output logic [DW-1:0] dbg_dout
);

    localparam logic [AW-1:0] NMAX = '1;
    localparam logic [63:0]   CMAX = (64'd1 << CW) - 64'd1;

    state_t        r_state;
    logic          r_run_q;
    logic          r_desc;
    logic          r_sgn;
    logic          r_flag;
    logic [AW-1:0] r_i;
    logic [AW-1:0] r_bound;
    logic [DW-1:0] r_p;
    logic [DW-1:0] r_q;
    logic [CW-1:0] r_cycles;
    logic [CW-1:0] r_swaps;

    logic          w_busy;
    logic          w_run_pe;
    logic          w_swap;
    logic          w_s_we;
    logic [AW-1:0] w_raddr;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_n;
    logic [DW-1:0] w_rd_lo;
    logic [DW-1:0] w_rd_hi;
    logic [DW-1:0] w_wdata;

    assign w_busy   = (r_state != S_IDLE);
    assign w_run_pe = run & ~r_run_q;
    assign w_raddr  = (r_state == S_INIT) ? '0 : r_i;

    // Counts beyond the array depth clamp to the last address.
    assign w_n = (w_rd_lo > DW'(NMAX)) ? NMAX : w_rd_lo[AW-1:0];

    always_comb begin
        w_swap = 1'b0;
        if (r_sgn) begin
            w_swap = r_desc ? ($signed(r_p) < $signed(r_q))
                            : ($signed(r_p) > $signed(r_q));
        end else begin
            w_swap = r_desc ? (r_p < r_q) : (r_p > r_q);
        end
    end

    assign w_s_we  = (r_state == S_WR_LO) || (r_state == S_WR_HI);
    assign w_waddr = (r_state == S_WR_HI) ? r_i + AW'(1) : r_i;
    assign w_wdata = (r_state == S_WR_HI) ? r_p : r_q;

    sort_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk       (clk),
        .i_busy    (w_busy),
        .i_s_we    (w_s_we),
        .i_s_waddr (w_waddr),
        .i_s_wdata (w_wdata),
        .i_d_we    (dbg_we),
        .i_d_addr  (dbg_addr),
        .i_d_wdata (dbg_din),
        .i_s_raddr (w_raddr),
        .o_s_lo    (w_rd_lo),
        .o_s_hi    (w_rd_hi),
        .o_d_dout  (dbg_dout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_run_q  <= 1'b0;
            r_desc   <= 1'b0;
            r_sgn    <= 1'b0;
            r_flag   <= 1'b0;
            r_i      <= '0;
            r_bound  <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_cycles <= '0;
            r_swaps  <= '0;
        end else begin
            r_run_q <= run;
            if (w_busy) begin
                r_cycles <= CW'(sat_inc(64'(r_cycles), CMAX));
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_run_pe) begin
                        r_desc   <= desc;
                        r_sgn    <= sgn;
                        r_cycles <= '0;
                        r_swaps  <= '0;
                        r_state  <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (w_n < AW'(2)) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_bound <= w_n - AW'(1);
                        r_i     <= AW'(1);
                        r_flag  <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_p     <= w_rd_lo;
                    r_q     <= w_rd_hi;
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    r_state <= w_swap ? S_WR_LO : S_ADV;
                end
                S_WR_LO: begin
                    r_state <= S_WR_HI;
                end
                S_WR_HI: begin
                    r_flag  <= 1'b1;
                    r_swaps <= CW'(sat_inc(64'(r_swaps), CMAX));
                    r_state <= S_ADV;
                end
                S_ADV: begin
                    if (r_i == r_bound) begin
                        r_state <= S_PASS_END;
                    end else begin
                        r_i     <= r_i + AW'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_PASS_END: begin
                    if (!r_flag || (r_bound == AW'(1))) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_bound <= r_bound - AW'(1);
                        r_i     <= AW'(1);
                        r_flag  <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done   = ~w_busy;
    assign cycles = r_cycles;
    assign swaps  = r_swaps;

endmodule

// File: tb/tb_sort_engine_p.sv
// Scoreboard bench for sort_engine_p: stimulus queues expected results,
// a monitor checks counters and memory whenever done rises.
module tb_sort_engine_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        run;
    logic        desc;
    logic        sgn;
    logic        we;
    logic [31:0] din;
    logic [7:0]  s_addr;
    logic [7:0]  m_addr;
    logic        m_act;
    logic        mon_busy;
    logic        ign;
    int          sel;
    wire  [7:0]  a = m_act ? m_addr : s_addr;

    logic        done0, done1, done2;
    logic [15:0] cyc0, sw0, cyc2, sw2;
    logic [3:0]  cyc1, sw1;
    logic [31:0] dout0, dout1, dout2;

    sort_engine_p #(.DW(32), .AW(8), .CW(16)) u0 (
        .clk(clk), .rstn(rstn), .run(run && sel == 0),
        .desc(desc), .sgn(sgn), .done(done0),
        .cycles(cyc0), .swaps(sw0), .dbg_addr(a),
        .dbg_din(din), .dbg_we(we && sel == 0), .dbg_dout(dout0)
    );

    sort_engine_p #(.DW(32), .AW(8), .CW(4)) u1 (
        .clk(clk), .rstn(rstn), .run(run && sel == 1),
        .desc(desc), .sgn(sgn), .done(done1),
        .cycles(cyc1), .swaps(sw1), .dbg_addr(a),
        .dbg_din(din), .dbg_we(we && sel == 1), .dbg_dout(dout1)
    );

    sort_engine_p #(.DW(32), .AW(4), .CW(16)) u2 (
        .clk(clk), .rstn(rstn), .run(run && sel == 2),
        .desc(desc), .sgn(sgn), .done(done2),
        .cycles(cyc2), .swaps(sw2), .dbg_addr(a[3:0]),
        .dbg_din(din), .dbg_we(we && sel == 2), .dbg_dout(dout2)
    );

    logic        m_done;
    logic [15:0] m_cyc;
    logic [15:0] m_sw;
    logic [31:0] m_dout;

    always_comb begin
        m_done = done0;
        m_cyc  = cyc0;
        m_sw   = sw0;
        m_dout = dout0;
        if (sel == 1) begin
            m_done = done1;
            m_cyc  = {12'd0, cyc1};
            m_sw   = {12'd0, sw1};
            m_dout = dout1;
        end else if (sel == 2) begin
            m_done = done2;
            m_cyc  = cyc2;
            m_sw   = sw2;
            m_dout = dout2;
        end
    end

    typedef struct packed {
        logic [15:0]       cyc;
        logic [15:0]       swp;
        logic [4:0]        cnt;
        logic [15:0][31:0] d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/none want event", nm);
    endtask

    initial begin
        logic prev;
        exp_t e;
        prev     = 1'b1;
        m_act    = 1'b0;
        m_addr   = '0;
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!ign && rstn && !prev && m_done) begin
                mon_busy = 1'b1;
                if (q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = q.pop_front();
                    chk("cycles", 32'(m_cyc), 32'(e.cyc));
                    chk("swaps", 32'(m_sw), 32'(e.swp));
                    m_act = 1'b1;
                    for (int k = 0; k <= int'(e.cnt); k++) begin
                        m_addr = 8'(k);
                        #1;
                        chk($sformatf("mem[%0d]", k), m_dout, e.d[k]);
                    end
                    m_act = 1'b0;
                end
                mon_busy = 1'b0;
            end
            prev = m_done;
        end
    end

    task automatic wr(input logic [7:0] ad, input logic [31:0] dt);
        @(negedge clk);
        s_addr = ad;
        din    = dt;
        we     = 1'b1;
        @(negedge clk);
        we     = 1'b0;
    endtask

    task automatic load(input logic [31:0] n0,
                        input logic [15:0][31:0] v, input int cnt);
        wr(8'd0, n0);
        for (int k = 1; k <= cnt; k++) begin
            wr(8'(k), v[k]);
        end
    endtask

    task automatic expect_res(input int c, input int s, input int cnt,
                              input logic [15:0][31:0] d);
        exp_t e;
        e.cyc = 16'(c);
        e.swp = 16'(s);
        e.cnt = 5'(cnt);
        e.d   = d;
        q.push_back(e);
    endtask

    task automatic start(input logic dsc, input logic sg);
        @(negedge clk);
        desc = dsc;
        sgn  = sg;
        run  = 1'b1;
        @(negedge clk);
        run  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while (!m_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!m_done) fail_now("done_timeout");
        repeat (2) @(negedge clk);
        t = 0;
        while ((q.size() > 0 || mon_busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0 || mon_busy) fail_now("monitor_timeout");
    endtask

    logic [15:0][31:0] v;
    logic [15:0][31:0] d;

    initial begin
        ign    = 1'b1;
        sel    = 0;
        run    = 1'b0;
        desc   = 1'b0;
        sgn    = 1'b0;
        we     = 1'b0;
        din    = '0;
        s_addr = '0;
        rstn   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(done0), 32'd1);
        chk("rst_cycles", 32'(cyc0), 32'd0);
        chk("rst_swaps", 32'(sw0), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        ign = 1'b0;

        v = '0; v[1] = 3; v[2] = 1; v[3] = 4; v[4] = 2;
        d = '0; d[0] = 4; d[1] = 1; d[2] = 2; d[3] = 3; d[4] = 4;
        load(32'd4, v, 4); expect_res(29, 3, 4, d);
        start(1'b0, 1'b0); wait_done();

        v = '0; v[1] = 1; v[2] = 2;
        d = '0; d[0] = 2; d[1] = 1; d[2] = 2;
        load(32'd2, v, 2); expect_res(6, 0, 2, d);
        start(1'b0, 1'b0); wait_done();

        v = '0; v[1] = 2; v[2] = 1;
        load(32'd2, v, 2); expect_res(8, 1, 2, d);
        start(1'b0, 1'b0); wait_done();

        v = '0; v[1] = 7;
        d = '0; d[0] = 0; d[1] = 7;
        load(32'd0, v, 1); expect_res(2, 0, 1, d);
        start(1'b0, 1'b0); wait_done();

        v = '0; v[1] = 9;
        d = '0; d[0] = 1; d[1] = 9;
        load(32'd1, v, 1); expect_res(2, 0, 1, d);
        start(1'b0, 1'b0); wait_done();

        v = '0; v[1] = 32'hFFFFFFFF; v[2] = 5; v[3] = 0;
        d = '0; d[0] = 3; d[1] = 5; d[2] = 0; d[3] = 32'hFFFFFFFF;
        load(32'd3, v, 3); expect_res(17, 2, 3, d);
        start(1'b1, 1'b1); wait_done();

        d = '0; d[0] = 3; d[1] = 32'hFFFFFFFF; d[2] = 5; d[3] = 0;
        load(32'd3, v, 3); expect_res(9, 0, 3, d);
        start(1'b1, 1'b0); wait_done();

        d = '0; d[0] = 3; d[1] = 32'hFFFFFFFF; d[2] = 0; d[3] = 5;
        load(32'd3, v, 3); expect_res(15, 1, 3, d);
        start(1'b0, 1'b1); wait_done();

        v = '0; v[1] = 2; v[2] = 1;
        d = '0; d[0] = 2; d[1] = 1; d[2] = 2;
        load(32'd0, v, 2); expect_res(8, 1, 2, d);
        @(negedge clk);
        desc = 1'b0; sgn = 1'b0;
        s_addr = 8'd0; din = 32'd2; we = 1'b1; run = 1'b1;
        @(negedge clk);
        we = 1'b0; run = 1'b0;
        wait_done();

        v = '0; v[1] = 3; v[2] = 1; v[3] = 4; v[4] = 2;
        d = '0; d[0] = 4; d[1] = 1; d[2] = 2; d[3] = 3; d[4] = 4;
        load(32'd4, v, 4); expect_res(29, 3, 4, d);
        start(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0; s_addr = 8'd2; din = 32'hDEAD; we = 1'b1;
        @(negedge clk);
        we = 1'b0; desc = 1'b1; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_done();

        v = '0; v[1] = 4; v[2] = 3; v[3] = 2; v[4] = 1;
        load(32'd4, v, 4);
        start(1'b0, 1'b0);
        repeat (6) @(negedge clk);
        ign  = 1'b1;
        rstn = 1'b0;
        #1;
        chk("midrst_done", 32'(done0), 32'd1);
        chk("midrst_cycles", 32'(cyc0), 32'd0);
        chk("midrst_swaps", 32'(sw0), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        ign = 1'b0;
        load(32'd4, v, 4); expect_res(35, 6, 4, d);
        start(1'b0, 1'b0); wait_done();

        sel = 1;
        load(32'd4, v, 4); expect_res(15, 6, 4, d);
        start(1'b0, 1'b0); wait_done();

        sel = 2;
        v = '0; d = '0; d[0] = 32'hFFFF;
        for (int k = 1; k <= 15; k++) begin
            v[k] = 32'(16 - k);
            d[k] = 32'(k);
        end
        load(32'hFFFF, v, 15); expect_res(541, 105, 15, d);
        start(1'b0, 1'b0); wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
